// File: rtl/mul_div_unit.sv
// Iterative unsigned MULTU/DIVU unit for the execute stage: one bit per cycle
// into HI/LO, which are read back combinationally through MFHI/MFLO.
module mul_div_unit #(
   parameter int         WIDTH = 32,
   parameter logic [5:0] MULTU = 6'b011001,
   parameter logic [5:0] DIVU  = 6'b011011,
   parameter logic [5:0] MFHI  = 6'b010000,
   parameter logic [5:0] MFLO  = 6'b010010
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dataOut
);

   localparam int CW = $clog2(WIDTH);

   // Handshake: a request is taken on a rising edge where start=1, busy=0 and
   // Signal is MULTU or DIVU; done pulses for one cycle once HI/LO are written.
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      count;
   logic               op_div;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_rem;
   logic [WIDTH:0]     div_diff;
   logic               accept;
   logic               last_iter;

   assign accept    = start && (state == IDLE) && ((Signal == MULTU) || (Signal == DIVU));
   assign last_iter = (state == RUN) && (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = RUN;
         RUN:     if (last_iter) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_rem - {1'b0, opnd};
      if (op_div) begin
         if (div_rem >= {1'b0, opnd}) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else                         acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done   <= 1'b0;
         count  <= '0;
         op_div <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= last_iter;
         if (accept) begin
            op_div <= (Signal == DIVU);
            opnd   <= (Signal == DIVU) ? dataB : dataA;
            acc    <= {{WIDTH{1'b0}}, ((Signal == DIVU) ? dataA : dataB)};
            count  <= '0;
         end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (last_iter) begin
               hi <= acc_step[2*WIDTH-1:WIDTH];
               lo <= acc_step[WIDTH-1:0];
            end
         end
      end
   end

   always_comb begin
      case (Signal)
         MFHI:    dataOut = hi;
         MFLO:    dataOut = lo;
         default: dataOut = '0;
      endcase
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Sequential unsigned multiply/divide unit beside the 32-bit ALU in the execute stage.
- Takes the same operand buses (dataA, dataB) and the same 6-bit function code (Signal) that drive the ALU.
- Runs MULTU/DIVU iteratively, one bit per cycle, into HI/LO registers.
- Returns HI/LO on dataOut for MFHI/MFLO, so execute-stage result selection treats it like the ALU.

Parameters:
WIDTH, 32, operand and HI/LO width
MULTU, 6'b011001, function code 25: unsigned multiply
DIVU, 6'b011011, function code 27: unsigned divide
MFHI, 6'b010000, function code 16: read HI
MFLO, 6'b010010, function code 18: read LO

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; block is in reset while reset=0
dataA  input  WIDTH  multiplicand / dividend
dataB  input  WIDTH  multiplier / divisor
Signal  input  6  function code, same encoding as the ALU
start  input  1  request to launch the operation named by Signal
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have been updated
dataOut  output  WIDTH  HI when Signal=MFHI, LO when Signal=MFLO, else 0

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, done=0, iteration count=0, internal operand/accumulator registers=0. dataOut then follows the combinational rule (0 for any Signal).
- States: IDLE (busy=0) and RUN (busy=1). done is a registered flag, not a state.
- Accept rule: on a rising edge with start=1, busy=0 and Signal in {MULTU, DIVU}:
  - latch dataA, dataB and the op;
  - count<=0, busy<=1, go to RUN.
- Ignored starts: start with any other Signal has no effect. start while busy=1 has no effect; the latched operands and op are not disturbed.
- RUN: one iteration per rising edge, count increments 0..WIDTH-1.
- Completion: on the edge that performs iteration WIDTH-1, write HI/LO, set busy<=0 and done<=1, return to IDLE.
- Latency: start edge at cycle 0; busy high cycles 1..32; done=1 in cycle 33 only. done clears on the next edge unless a new completion occurs.
- Back-to-back: a new start is accepted on the same edge at which done is high, since busy=0 in that cycle.
- MULTU: shift-add over a 2*WIDTH-bit product, unsigned. HI = product[63:32], LO = product[31:0].
- DIVU: restoring unsigned division. LO = quotient, HI = remainder.
- Divide by zero: natural restoring result, LO=32'hFFFFFFFF, HI=dividend. No exception flag.
- HI/LO stability: registers change only on the completion edge (or reset). MFHI/MFLO issued while busy return the previous values.
- dataOut is purely combinational from Signal, HI and LO; zero latency.
- Reset mid-operation: aborts immediately, all state returns to reset values, and no done pulse is produced.
- Operands are captured at start, so dataA/dataB/Signal may change freely during RUN.

Test Plan:
- MULTU 7 x 6, start one cycle -> busy high exactly 32 cycles, done pulse in cycle 33, then MFLO gives 42 and MFHI gives 0.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001. MFLO during busy still returns the prior LO.
- DIVU 100 / 7 -> LO=14, HI=2. Then DIVU 5 / 0 -> LO=32'hFFFFFFFF, HI=5.
- Start pulse with Signal=ADD (32), then start with DIVU while busy and different operands -> first ignored (busy stays 0); second ignored, original result unchanged, single done pulse.
- Drive reset=0 mid-RUN at iteration 10 of MULTU 3 x 3, then release -> busy=0, done=0, HI=LO=0 immediately, and no done pulse afterwards.
- Issue MULTU 2 x 3, then a second start (DIVU 9 / 2) on the edge where done=1 -> first gives LO=6; second is accepted, and 32 cycles later gives LO=4, HI=1.
